// File: rtl/pet_pkg.sv
// pet_pkg: shared definitions for pet_needs_engine
// Contents: FSM state encoding, seven-segment glyphs (a..g in bits 0..6), and level/glyph helper functions.
package pet_pkg;
    typedef enum logic [1:0] {ST_RUN = 2'd0, ST_TEST = 2'd1, ST_DEAD = 2'd2} pet_state_t;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    // Indices 11..15 are blank so any 4-bit value decodes safely.
    localparam logic [6:0] SEG_GLYPH [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
    };
    function automatic int lvl_bits(input int max_val);
        return $clog2(max_val + 1);
    endfunction
    function automatic logic [6:0] seg_glyph(input int v);
        return (v < 0 || v > 10) ? SEG_BLANK : SEG_GLYPH[v[3:0]];
    endfunction
endpackage

// File: rtl/need_channel.sv
// need_channel: one need level with its decay counter, saturating feed/decay and feed/decay collision rule
// Ports: clk, reset (async, active-high); revive (restore LVL_INIT, clear counter); feed (one-cycle feed pulse);
//        test_mode (feed toggles 1 <-> LVL_MAX); dec_en (tick that advances the decay counter);
//        period (decay period in ticks); level (registered need level).
module need_channel #(
    parameter int LVL_W = 4,
    parameter int LVL_MAX = 10,
    parameter int LVL_INIT = 8,
    parameter int PERIOD_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                revive,
    input  logic                feed,
    input  logic                test_mode,
    input  logic                dec_en,
    input  logic [PERIOD_W-1:0] period,
    output logic [LVL_W-1:0]    level
);
    logic [PERIOD_W-1:0] cnt, cnt_inc;
    logic                decay;
    logic [LVL_W-1:0]    fed, dropped;

    always_comb begin
        cnt_inc = cnt + 1'b1;
        decay   = dec_en && cnt_inc == period;
        fed     = test_mode ? (level == LVL_W'(1) ? LVL_W'(LVL_MAX) : LVL_W'(1))
                            : (level == LVL_W'(LVL_MAX) ? level : level + 1'b1);
        dropped = level == '0 ? level : level - 1'b1;
    end

    // A feed and a decay landing together cancel out; the counter still clears.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            level <= LVL_W'(LVL_INIT);
            cnt   <= '0;
        end else if (revive) begin
            level <= LVL_W'(LVL_INIT);
            cnt   <= '0;
        end else begin
            if (dec_en) cnt <= decay ? '0 : cnt_inc;
            if (feed != decay) level <= feed ? fed : dropped;
        end
endmodule

// File: rtl/pet_needs_engine.sv
// pet_needs_engine: multi-need pet status engine with tick prescaler, button select/feed, TEST and DEAD states
// Ports: clk, reset (async, active-high); btn_need/btn_test/btn_revive (debounced levels, rising edges act);
//        decay_hold (per-channel decay freeze); sel_idx/sel_level/mood_happy (selected channel view);
//        levels (all levels packed, ch0 in LSBs); state (0 RUN, 1 TEST, 2 DEAD); tick (one-cycle enable).
// Optional: define PET_NEEDS_SEVEN_SEG_EN to add seg_display[6:0], a registered decode of sel_level.
module pet_needs_engine
    import pet_pkg::*;
#(
    parameter int N_NEEDS = 4,
    parameter int LVL_W = 4,
    parameter int LVL_MAX = 10,
    parameter int LVL_INIT = 8,
    parameter int MOOD_THRESH = 5,
    parameter int TICK_DIV = 1875000,
    parameter int PERIOD_W = 8,
    parameter logic [N_NEEDS*PERIOD_W-1:0] DECAY_PER = {8'd50, 8'd70, 8'd100, 8'd120}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_NEEDS-1:0]         btn_need,
    input  logic                       btn_test,
    input  logic                       btn_revive,
    input  logic [N_NEEDS-1:0]         decay_hold,
    output logic [$clog2(N_NEEDS)-1:0] sel_idx,
    output logic [LVL_W-1:0]           sel_level,
    output logic                       mood_happy,
    output logic [N_NEEDS*LVL_W-1:0]   levels,
    output logic [1:0]                 state,
    output logic                       tick
`ifdef PET_NEEDS_SEVEN_SEG_EN
    ,
    output logic [6:0]                 seg_display
`endif
);
    localparam int SW = $clog2(N_NEEDS);
    localparam int TW = $clog2(TICK_DIV);

    if (N_NEEDS < 2 || N_NEEDS > 8 || TICK_DIV < 2 || lvl_bits(LVL_MAX) > LVL_W || LVL_INIT > LVL_MAX) begin : g_bad_params
        $error("pet_needs_engine: illegal parameter set");
    end

    pet_state_t           st, st_nx;
    logic [TW-1:0]        pcnt;
    logic [N_NEEDS+1:0]   s1, s2, pv, edg;
    logic [N_NEEDS-1:0]   need_edge, feed;
    logic                 test_edge, rev_edge, hit, active, any_zero;
    logic [SW-1:0]        idx;

    assign edg = s2 & ~pv;
    assign {rev_edge, test_edge, need_edge} = edg;
    assign active = st != ST_DEAD;
    assign state = st;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            pcnt <= '0;
            tick <= 1'b0;
            s1   <= '0;
            s2   <= '0;
            pv   <= '0;
        end else begin
            pcnt <= pcnt == TW'(TICK_DIV - 1) ? '0 : pcnt + 1'b1;
            tick <= pcnt == TW'(TICK_DIV - 1);
            s1   <= {btn_revive, btn_test, btn_need};
            s2   <= s1;
            pv   <= s2;
        end

    // Descending scan so the lowest simultaneous need edge wins.
    always_comb begin
        hit      = 1'b0;
        idx      = '0;
        any_zero = 1'b0;
        for (int i = N_NEEDS - 1; i >= 0; i--)
            if (need_edge[i]) begin
                hit = 1'b1;
                idx = SW'(i);
            end
        for (int i = 0; i < N_NEEDS; i++)
            any_zero = any_zero | (levels[i*LVL_W +: LVL_W] == '0);
        feed  = active && hit && !rev_edge && idx == sel_idx ? N_NEEDS'(1) << idx : '0;
        st_nx = rev_edge                      ? ST_RUN  :
                test_edge && st == ST_RUN     ? ST_TEST :
                test_edge && st == ST_TEST    ? ST_RUN  :
                st == ST_RUN && any_zero      ? ST_DEAD : st;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            st         <= ST_RUN;
            sel_idx    <= '0;
            sel_level  <= LVL_W'(LVL_INIT);
            mood_happy <= LVL_INIT >= MOOD_THRESH;
        end else begin
            st         <= st_nx;
            sel_idx    <= rev_edge ? '0 : active && hit ? idx : sel_idx;
            sel_level  <= levels[sel_idx*LVL_W +: LVL_W];
            mood_happy <= levels[sel_idx*LVL_W +: LVL_W] >= LVL_W'(MOOD_THRESH);
        end

    for (genvar c = 0; c < N_NEEDS; c++) begin : g_ch
        need_channel #(
            .LVL_W(LVL_W), .LVL_MAX(LVL_MAX), .LVL_INIT(LVL_INIT), .PERIOD_W(PERIOD_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .revive    (rev_edge),
            .feed      (feed[c]),
            .test_mode (st == ST_TEST),
            .dec_en    (tick && st == ST_RUN && !decay_hold[c]),
            .period    (DECAY_PER[c*PERIOD_W +: PERIOD_W]),
            .level     (levels[c*LVL_W +: LVL_W])
        );
    end

`ifdef PET_NEEDS_SEVEN_SEG_EN
    always_ff @(posedge clk or posedge reset)
        if (reset) seg_display <= seg_glyph(LVL_INIT);
        else seg_display <= st == ST_DEAD ? SEG_DASH : seg_glyph(int'(sel_level));
`endif
endmodule

// File: tb/tb_pet_needs_engine.sv
// tb_pet_needs_engine: directed self-checking bench for pet_needs_engine (TICK_DIV=4, default decay periods)
module tb_pet_needs_engine;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  btn_need = '0;
    logic [3:0]  decay_hold = '0;
    logic        btn_test = 1'b0;
    logic        btn_revive = 1'b0;
    logic [1:0]  sel_idx;
    logic [3:0]  sel_level;
    logic        mood_happy;
    logic [15:0] levels;
    logic [1:0]  state;
    logic        tick;
`ifdef PET_NEEDS_SEVEN_SEG_EN
    logic [6:0]  seg_display;
`endif
    int errors = 0;
    int checks = 0;

    pet_needs_engine #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_need   (btn_need),
        .btn_test   (btn_test),
        .btn_revive (btn_revive),
        .decay_hold (decay_hold),
        .sel_idx    (sel_idx),
        .sel_level  (sel_level),
        .mood_happy (mood_happy),
        .levels     (levels),
        .state      (state),
        .tick       (tick)
`ifdef PET_NEEDS_SEVEN_SEG_EN
        ,
        .seg_display(seg_display)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] lv(input int i);
        return levels[i*4 +: 4];
    endfunction

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] need, input logic tst, input logic rev);
        btn_need = need;
        btn_test = tst;
        btn_revive = rev;
        clks(5);
        btn_need = '0;
        btn_test = 1'b0;
        btn_revive = 1'b0;
        clks(5);
    endtask

    task automatic count_ticks(input int n);
        int c;
        int guard;
        c = 0;
        guard = 0;
        while (c < n && guard < n * 4 + 40) begin
            @(negedge clk);
            guard++;
            if (tick) c++;
        end
        if (c < n) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got %0d ticks expected %0d", c, n);
        end
    endtask

    task automatic ticks_to_change(input int ch, output int n);
        logic [3:0] start;
        int guard;
        start = lv(ch);
        guard = 0;
        n = 0;
        while (lv(ch) === start && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (tick) n++;
        end
        checks++;
        if (lv(ch) === start) begin
            errors++;
            $display("FAIL decay_timeout_ch%0d: level stuck at %0d", ch, start);
        end
    endtask

    task automatic test_reset;
        logic [11:0] pat;
        reset = 1'b1;
        clks(2);
        checks++; if (levels !== 16'h8888) begin errors++; $display("FAIL reset_levels: got %h expected 8888", levels); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
        checks++; if (sel_idx !== 2'd0) begin errors++; $display("FAIL reset_sel_idx: got %0d expected 0", sel_idx); end
        checks++; if (mood_happy !== 1'b1) begin errors++; $display("FAIL reset_mood: got %0d expected 1", mood_happy); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0d expected 0", tick); end
        checks++; if (sel_level !== 4'd8) begin errors++; $display("FAIL reset_sel_level: got %0d expected 8", sel_level); end
        reset = 1'b0;
        pat = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            pat = {pat[10:0], tick};
        end
        checks++; if (pat !== 12'b0001_0001_0001) begin errors++; $display("FAIL tick_pattern: got %b expected 000100010001", pat); end
    endtask

    task automatic test_select_feed;
        decay_hold = 4'hF;
        press(4'b0100, 1'b0, 1'b0);
        checks++; if (sel_idx !== 2'd2) begin errors++; $display("FAIL select_idx: got %0d expected 2", sel_idx); end
        checks++; if (lv(2) !== 4'd8) begin errors++; $display("FAIL select_no_feed: got %0d expected 8", lv(2)); end
        press(4'b0100, 1'b0, 1'b0);
        checks++; if (lv(2) !== 4'd9) begin errors++; $display("FAIL feed_inc: got %0d expected 9", lv(2)); end
        checks++; if (sel_level !== 4'd9) begin errors++; $display("FAIL feed_sel_level: got %0d expected 9", sel_level); end
        repeat (3) press(4'b0100, 1'b0, 1'b0);
        checks++; if (lv(2) !== 4'd10) begin errors++; $display("FAIL feed_saturate: got %0d expected 10", lv(2)); end
        checks++; if (sel_level !== 4'd10) begin errors++; $display("FAIL feed_sat_sel_level: got %0d expected 10", sel_level); end
        press(4'b1010, 1'b0, 1'b0);
        checks++; if (sel_idx !== 2'd1) begin errors++; $display("FAIL multi_edge_lowest: got %0d expected 1", sel_idx); end
        checks++; if (levels !== 16'h8A88) begin errors++; $display("FAIL multi_edge_no_feed: got %h expected 8a88", levels); end
        press(4'b0010, 1'b0, 1'b0);
        checks++; if (lv(1) !== 4'd9) begin errors++; $display("FAIL feed_ch1: got %0d expected 9", lv(1)); end
    endtask

    task automatic test_decay_hold;
        int n;
        press(4'b0000, 1'b0, 1'b1);
        checks++; if (levels !== 16'h8888) begin errors++; $display("FAIL revive_levels: got %h expected 8888", levels); end
        checks++; if (sel_idx !== 2'd0) begin errors++; $display("FAIL revive_sel_idx: got %0d expected 0", sel_idx); end
        decay_hold = 4'b0111;
        ticks_to_change(3, n);
        ticks_to_change(3, n);
        checks++; if (n !== 50) begin errors++; $display("FAIL decay_period_ch3: got %0d ticks expected 50", n); end
        checks++; if (lv(3) !== 4'd6) begin errors++; $display("FAIL decay_level_ch3: got %0d expected 6", lv(3)); end
        count_ticks(10);
        @(negedge clk);
        decay_hold = 4'hF;
        count_ticks(100);
        checks++; if (lv(3) !== 4'd6) begin errors++; $display("FAIL hold_frozen: got %0d expected 6", lv(3)); end
        @(negedge clk);
        decay_hold = 4'b0111;
        ticks_to_change(3, n);
        checks++; if (n !== 40) begin errors++; $display("FAIL hold_resume: got %0d ticks expected 40", n); end
        checks++; if (lv(3) !== 4'd5) begin errors++; $display("FAIL hold_resume_level: got %0d expected 5", lv(3)); end
    endtask

    task automatic test_test_mode;
        press(4'b0000, 1'b0, 1'b1);
        decay_hold = 4'h0;
        press(4'b0000, 1'b1, 1'b0);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL enter_test: got %0d expected 1", state); end
        press(4'b0001, 1'b0, 1'b0);
        checks++; if (lv(0) !== 4'd1) begin errors++; $display("FAIL test_feed_low: got %0d expected 1", lv(0)); end
        checks++; if (mood_happy !== 1'b0) begin errors++; $display("FAIL test_mood_low: got %0d expected 0", mood_happy); end
        press(4'b0001, 1'b0, 1'b0);
        checks++; if (lv(0) !== 4'd10) begin errors++; $display("FAIL test_feed_high: got %0d expected 10", lv(0)); end
        clks(600);
        checks++; if (levels !== 16'h888A) begin errors++; $display("FAIL test_no_decay: got %h expected 888a", levels); end
        press(4'b0000, 1'b1, 1'b0);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL exit_test: got %0d expected 0", state); end
    endtask

    task automatic test_dead_revive;
        int guard;
        press(4'b0000, 1'b0, 1'b1);
        decay_hold = 4'b1101;
        guard = 0;
        while (lv(1) !== 4'd0 && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        checks++; if (lv(1) !== 4'd0) begin errors++; $display("FAIL dead_timeout: got %0d expected 0", lv(1)); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL dead_latency: got %0d expected 0", state); end
        @(negedge clk);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL dead_state: got %0d expected 2", state); end
        press(4'b0001, 1'b0, 1'b0);
        checks++; if (levels !== 16'h8808) begin errors++; $display("FAIL dead_feed_ignored: got %h expected 8808", levels); end
        press(4'b1000, 1'b0, 1'b0);
        checks++; if (sel_idx !== 2'd0) begin errors++; $display("FAIL dead_select_ignored: got %0d expected 0", sel_idx); end
        press(4'b0000, 1'b1, 1'b0);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL dead_test_ignored: got %0d expected 2", state); end
        press(4'b0000, 1'b0, 1'b1);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL revive_state: got %0d expected 0", state); end
        checks++; if (levels !== 16'h8888) begin errors++; $display("FAIL revive_dead_levels: got %h expected 8888", levels); end
    endtask

    task automatic test_collision;
        int n;
        int win;
        int bad;
        press(4'b0000, 1'b0, 1'b1);
        decay_hold = 4'b1110;
        ticks_to_change(0, n);
        count_ticks(119);
        clks(2);
        btn_need = 4'b0001;
        win = 0;
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (tick) win++;
            if (lv(0) !== 4'd7) bad++;
        end
        btn_need = '0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL collision_level: got %0d cycles off 7 expected 0", bad); end
        ticks_to_change(0, n);
        checks++; if (win + n !== 121) begin errors++; $display("FAIL collision_counter_clear: got %0d ticks expected 121", win + n); end
        checks++; if (lv(0) !== 4'd6) begin errors++; $display("FAIL collision_next_decay: got %0d expected 6", lv(0)); end
    endtask

    task automatic test_revive_priority;
        press(4'b0000, 1'b0, 1'b1);
        decay_hold = 4'hF;
        press(4'b0000, 1'b1, 1'b1);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL revive_over_test: got %0d expected 0", state); end
        press(4'b0000, 1'b1, 1'b0);
        press(4'b0001, 1'b0, 1'b0);
        checks++; if (lv(0) !== 4'd1) begin errors++; $display("FAIL prio_setup: got %0d expected 1", lv(0)); end
        press(4'b0001, 1'b1, 1'b1);
        checks++; if (lv(0) !== 4'd8) begin errors++; $display("FAIL revive_over_feed: got %0d expected 8", lv(0)); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL revive_from_test: got %0d expected 0", state); end
        press(4'b0100, 1'b0, 1'b1);
        checks++; if (sel_idx !== 2'd0) begin errors++; $display("FAIL revive_over_select: got %0d expected 0", sel_idx); end
    endtask

    initial begin
        test_reset();
        test_select_feed();
        test_decay_hold();
        test_test_mode();
        test_dead_revive();
        test_collision();
        test_revive_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
